controle_rodada: RTL

- Turn-sequencing FSM for jogao_da_velha, the 9x9 "ultimate" tic-tac-toe.
- Takes debounced one-hot button strobes and decides whether each press selects a macro board or a micro cell.
- Validates the press against occupancy masks from the datapath and drives the datapath write enables.
- Alternates players and forces the next macro from the last micro cell played. Sits between the button edge detector and the board-storage datapath.

---
 rtl/controle_rodada_if.sv | 34 +++
 rtl/controle_rodada.sv | 114 +++++++++++
 2 files changed

// File: rtl/controle_rodada_if.sv
// Bundles the button/datapath handshake between the round controller and the
// board-storage datapath of jogao_da_velha.
interface controle_rodada_if #(
    parameter int N_CASAS = 9,
    parameter int W_IDX   = 4
);
    logic               iniciar;
    logic               tem_jogada;
    logic [N_CASAS-1:0] botoes;
    logic [N_CASAS-1:0] macro_fechado;
    logic [N_CASAS-1:0] micro_ocupado;
    logic               fim_jogo;
    logic               jogador;
    logic               jogar_macro;
    logic               jogar_micro;
    logic [W_IDX-1:0]   macro_atual;
    logic [W_IDX-1:0]   micro_atual;
    logic               zera_tab;
    logic               registra_micro;
    logic               pronto;
    logic [3:0]         db_estado;

    modport master (
        output iniciar, tem_jogada, botoes, macro_fechado, micro_ocupado, fim_jogo,
        input  jogador, jogar_macro, jogar_micro, macro_atual, micro_atual,
               zera_tab, registra_micro, pronto, db_estado
    );

    modport slave (
        input  iniciar, tem_jogada, botoes, macro_fechado, micro_ocupado, fim_jogo,
        output jogador, jogar_macro, jogar_micro, macro_atual, micro_atual,
               zera_tab, registra_micro, pronto, db_estado
    );
endinterface

// File: rtl/controle_rodada.sv
// Turn-sequencing FSM for 9x9 ultimate tic-tac-toe: decodes one-hot presses into
// macro/micro selections, validates them and drives the datapath write strobes.
module controle_rodada #(
    parameter int N_CASAS = 9,
    parameter int W_IDX   = 4
) (
    input logic             clock,
    input logic             reset,
    controle_rodada_if.slave bus
);

    typedef enum logic [3:0] {
        INICIAL      = 4'd0,
        PREPARA      = 4'd1,
        ESPERA_MACRO = 4'd2,
        ESPERA_MICRO = 4'd3,
        REGISTRA     = 4'd4,
        AGUARDA      = 4'd5,
        CHECA        = 4'd6,
        FIM          = 4'd7
    } estado_t;

    estado_t          r_estado;
    estado_t          w_prox_estado;
    logic             r_jogador;
    logic             w_prox_jogador;
    logic [W_IDX-1:0] r_macro;
    logic [W_IDX-1:0] w_prox_macro;
    logic [W_IDX-1:0] r_micro;
    logic [W_IDX-1:0] w_prox_micro;
    logic [W_IDX-1:0] w_idx;
    logic             w_valida;

    // A press only counts when exactly one button is set.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < N_CASAS; i++) begin
            if (bus.botoes[i]) begin
                w_idx = W_IDX'(i);
            end
        end
        w_valida = bus.tem_jogada && $onehot(bus.botoes);
    end

    always_comb begin
        w_prox_estado  = r_estado;
        w_prox_jogador = r_jogador;
        w_prox_macro   = r_macro;
        w_prox_micro   = r_micro;
        case (r_estado)
            INICIAL: begin
                if (bus.iniciar) w_prox_estado = PREPARA;
            end
            PREPARA: begin
                w_prox_jogador = 1'b0;
                w_prox_estado  = ESPERA_MACRO;
            end
            ESPERA_MACRO: begin
                if (w_valida && !bus.macro_fechado[w_idx]) begin
                    w_prox_macro  = w_idx;
                    w_prox_estado = ESPERA_MICRO;
                end
            end
            ESPERA_MICRO: begin
                if (w_valida && !bus.micro_ocupado[w_idx]) begin
                    w_prox_micro  = w_idx;
                    w_prox_estado = REGISTRA;
                end
            end
            REGISTRA: w_prox_estado = AGUARDA;
            AGUARDA:  w_prox_estado = CHECA;
            CHECA: begin
                if (bus.fim_jogo) begin
                    w_prox_estado = FIM;
                end else begin
                    // The cell just played names the macro the opponent must use.
                    w_prox_jogador = ~r_jogador;
                    w_prox_macro   = r_micro;
                    w_prox_estado  = bus.macro_fechado[r_micro] ? ESPERA_MACRO : ESPERA_MICRO;
                end
            end
            FIM: begin
                if (bus.iniciar) w_prox_estado = PREPARA;
            end
            default: w_prox_estado = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado  <= INICIAL;
            r_jogador <= 1'b0;
            r_macro   <= '0;
            r_micro   <= '0;
        end else begin
            r_estado  <= w_prox_estado;
            r_jogador <= w_prox_jogador;
            r_macro   <= w_prox_macro;
            r_micro   <= w_prox_micro;
        end
    end

    // Every strobe and level is decoded straight from the state, so reset clears them at once.
    assign bus.jogador        = r_jogador;
    assign bus.jogar_macro    = (r_estado == ESPERA_MACRO);
    assign bus.jogar_micro    = (r_estado == ESPERA_MICRO);
    assign bus.macro_atual    = r_macro;
    assign bus.micro_atual    = r_micro;
    assign bus.zera_tab       = (r_estado == PREPARA);
    assign bus.registra_micro = (r_estado == REGISTRA);
    assign bus.pronto         = (r_estado == FIM);
    assign bus.db_estado      = r_estado;

endmodule
